// File: rtl/dropout_mask_sequencer.sv
// Dropout mask sequencer for an 8-lane neuron datapath.
// A Galois LFSR builds a per-lane keep mask one lane per cycle. The mask is
// held for a batch of vectors, then rebuilt. Train-mode vectors are masked and
// upscaled. Inference-mode vectors pass through unchanged.
//
// Handshake: a vector moves on a rising edge where valid & ready are both high.
// valid never waits for ready. Data is held stable while valid is high and
// ready is low. in_ready is high only in RUN, and only while the single output
// register is empty or being drained in the same cycle.
module dropout_mask_sequencer #(
  parameter int          LANES       = 8,
  parameter int          DW          = 8,
  parameter int          THRESH      = 128,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          SCALE_SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  train_en,
  input  logic                  seed_load,
  input  logic [15:0]           seed_in,
  input  logic [7:0]            batch_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic [LANES-1:0]      out_mask,
  output logic [15:0]           mask_epoch
);

  typedef enum logic [1:0] {IDLE, GEN, RUN} state_t;

  localparam logic [8:0] THRESH9 = 9'(THRESH);

  state_t               state;
  logic [15:0]          lfsr;
  logic [2:0]           gen_cnt;
  logic [7:0]           vec_cnt;
  logic [LANES-1:0]     mask;

  logic [15:0]          lfsr_next;
  logic                 keep_bit;
  logic                 accept;
  logic [7:0]           last_idx;
  logic [LANES*DW-1:0]  train_data;
  logic [2*DW-1:0]      wide;
  logic [DW-1:0]        lane_sat;

  // Galois step with taps 0xB400 and the keep decision for the lane being built
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign keep_bit  = ({1'b0, lfsr_next[7:0]} >= THRESH9);

  // A batch length of zero behaves as one vector per mask
  assign last_idx = (batch_len == 8'd0) ? 8'd0 : batch_len - 8'd1;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Masked and saturating-upscaled copy of the input vector for train mode
  always_comb begin
    train_data = '0;
    wide       = '0;
    lane_sat   = '0;
    for (int i = 0; i < LANES; i++) begin
      wide     = {{DW{1'b0}}, in_data[i*DW +: DW]} << SCALE_SHIFT;
      lane_sat = (wide > 16'd255) ? 8'hFF : wide[DW-1:0];
      train_data[i*DW +: DW] = mask[i] ? lane_sat : '0;
    end
  end

  // Mask generation FSM, batch counting and the output register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      lfsr       <= SEED;
      gen_cnt    <= 3'd0;
      vec_cnt    <= 8'd0;
      mask       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mask   <= '0;
      mask_epoch <= 16'd0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        if (train_en) begin
          out_data <= train_data;
          out_mask <= mask;
        end else begin
          out_data <= in_data;
          out_mask <= '1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          state   <= GEN;
          gen_cnt <= 3'd0;
        end
        GEN: begin
          lfsr          <= lfsr_next;
          mask[gen_cnt] <= keep_bit;
          gen_cnt       <= gen_cnt + 3'd1;
          if (gen_cnt == 3'd7) begin
            vec_cnt <= 8'd0;
            state   <= RUN;
            // An aborted generation never counts as a completed one
            if (!seed_load) mask_epoch <= mask_epoch + 16'd1;
          end
        end
        RUN: begin
          if (accept && train_en) begin
            // >= so that a shrunk batch_len closes the batch immediately
            if (vec_cnt >= last_idx) begin
              state   <= GEN;
              gen_cnt <= 3'd0;
              vec_cnt <= 8'd0;
            end else begin
              vec_cnt <= vec_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Reseeding restarts generation from any state and leaves the output alone
      if (seed_load) begin
        lfsr    <= (seed_in == 16'd0) ? SEED : seed_in;
        vec_cnt <= 8'd0;
        gen_cnt <= 3'd0;
        state   <= GEN;
      end
    end
  end

endmodule

// File: doc/dropout_mask_sequencer.md
Name: dropout_mask_sequencer

Overview:
Controller for the 8-lane neuron dropout datapath. A 16-bit LFSR generates a per-lane keep mask, one lane per cycle. The mask is held for a programmable number of vectors (one batch), then regenerated. The block applies the mask to a valid/ready vector stream, with optional inverted-dropout upscaling of the kept lanes. It sits between a layer's activation output and the next layer's input buffer, and passes data through unchanged in inference mode.

Parameters:
LANES, 8, number of neuron lanes; the spec is fixed at 8
DW, 8, bits per lane, unsigned
THRESH, 128, 9-bit drop threshold (0..256); a lane is dropped when its random byte < THRESH; 128 gives 50%, 0 never drops, 256 always drops
SEED, 16'hACE1, LFSR value after reset; also replaces any zero seed
SCALE_SHIFT, 1, left shift applied to kept lanes in train mode, saturating at 255; 0 disables scaling

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low (0 = reset)
train_en  in  1  1 = apply dropout; 0 = inference pass-through
seed_load  in  1  one-cycle pulse; loads seed_in into the LFSR and forces regeneration
seed_in  in  16  new LFSR seed
batch_len  in  8  vectors per mask; 0 is treated as 1
in_valid  in  1  input vector valid
in_ready  out  1  input vector accepted when in_valid & in_ready
in_data  in  64  lane i = bits [8i+7:8i]
out_valid  out  1  output vector valid
out_ready  in  1  downstream ready
out_data  out  64  masked/scaled vector
out_mask  out  8  keep mask used for out_data (1 = kept)
mask_epoch  out  16  count of completed mask generations, wraps

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE, lfsr=SEED, gen_cnt=0, vec_cnt=0, mask=8'h00.
  - out_valid=0, out_data=0, out_mask=0, mask_epoch=0, in_ready=0.
  - Reset mid-transfer discards the held output and any partial mask.
- LFSR is Galois, taps 0xB400: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It steps only in GEN. A seed_in of 0 loads SEED instead.
- FSM:
  - IDLE: lasts exactly one cycle, then goes to GEN.
  - GEN: 8 cycles, gen_cnt 0..7. Each cycle the LFSR steps and mask[gen_cnt] = ({1'b0, next[7:0]} >= THRESH). On gen_cnt=7: mask_epoch+1, vec_cnt=0, go to RUN. in_ready=0 throughout GEN.
  - RUN: in_ready = !out_valid | out_ready (single-stage output register, full throughput).
- On accept in RUN:
  - Output register loads on the next edge, so latency is 1 cycle.
  - train_en=1: lane i = mask[i] ? sat255(in_lane << SCALE_SHIFT) : 0, and out_mask=mask.
  - train_en=0: out_data=in_data, out_mask=8'hFF.
  - Train-mode accept: if vec_cnt == max(batch_len,1)-1, go to GEN and set vec_cnt=0; otherwise vec_cnt+1.
  - Inference accepts never change vec_cnt or trigger GEN.
- Output handshake:
  - out_valid clears on out_ready when there is no simultaneous accept.
  - out_data and out_mask hold stable while out_valid & !out_ready.
- train_en is sampled per accept. Toggling it does not force regeneration or reset vec_cnt.
- seed_load (any state except reset):
  - Loads the LFSR, sets vec_cnt=0 and gen_cnt=0, and enters GEN next cycle. A GEN in progress is aborted and restarted; mask_epoch does not increment for the aborted run.
  - An accept in the same cycle as seed_load is still honoured with the old mask, and its vec_cnt update is overridden to 0.
  - The output register is unaffected.
- batch_len is sampled at each compare. Lowering it below the current vec_cnt+1 triggers GEN at the next train accept.
- mask_epoch wraps 16'hFFFF to 0.

Test Plan:
- Reset release, THRESH=0, SCALE_SHIFT=1, train_en=1, in_data lanes all 8'h50 -> in_ready rises on cycle 10 after release (1 IDLE + 8 GEN + 1); out_data lanes 8'hA0, out_mask=8'hFF, mask_epoch=1, out_valid 1 cycle after accept.
- THRESH=256, train_en=1, lanes 8'hFF -> out_data=0, out_mask=8'h00. Then train_en=0 with same input -> out_data all 8'hFF, out_mask=8'hFF, no GEN.
- Saturation: THRESH=0, lane value 8'h90, SCALE_SHIFT=1 -> lane 8'hFF; lane value 8'h7F -> 8'hFE.
- batch_len=3, continuous valid, out_ready=1 -> in_ready drops for exactly 8 cycles after every 3rd accept; mask_epoch increments 1,2,3 after 9 accepts. batch_len=0 behaves as 1.
- seed_load with seed_in=16'h1234 during GEN cycle 4 -> GEN restarts with 8 full cycles; mask equals golden Galois model from 0x1234; mask_epoch +1 only. seed_in=0 -> mask equals model from 0xACE1.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_mask stable, in_ready=0. Assert reset=0 in that window -> next cycle out_valid=0, state IDLE.
